// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch flush and memory-wait freeze control for the ID stage.
// Bubble length is set by LOAD_LAT; stall_count is a saturating count of held cycles.
module hazard_stall_controller #(
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
   input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
   input  logic                  IF_ID_rs1_used,
   input  logic                  IF_ID_rs2_used,
   input  logic [REG_ADDR_W-1:0] ID_EX_rd,
   input  logic                  ID_EX_memRead,
   input  logic                  EX_MEM_memRead,
   input  logic                  mem_ready,
   input  logic                  branch_taken,
   input  logic                  perf_clear,
   output logic                  clk_gate,
   output logic                  contol_signals_select,
   output logic                  IF_ID_flush,
   output logic                  pipe_freeze,
   output logic [CNT_W-1:0]      stall_count
);

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [3:0] HOLD_INIT = 4'(LOAD_LAT - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       hz, mw;

   assign hz = ID_EX_memRead && (ID_EX_rd != '0) &&
               ((IF_ID_rs1_used && (IF_ID_rs1 == ID_EX_rd)) ||
                (IF_ID_rs2_used && (IF_ID_rs2 == ID_EX_rd)));
   assign mw = EX_MEM_memRead && !mem_ready;

   // Rows are in priority order: memory wait freezes everything, a taken branch
   // then cancels any stall, otherwise the hold counter or a fresh hazard stalls.
   always_comb begin
      clk_gate              = 1'b1;
      contol_signals_select = 1'b1;
      IF_ID_flush           = 1'b0;
      pipe_freeze           = 1'b0;
      state_nxt             = state;
      cnt_nxt               = cnt;
      if (!rst_n) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else if (mw) begin
         pipe_freeze = 1'b1;
         clk_gate    = 1'b0;
      end else if (branch_taken) begin
         IF_ID_flush           = 1'b1;
         contol_signals_select = 1'b0;
         state_nxt             = RUN;
         cnt_nxt               = '0;
      end else if (state == HOLD) begin
         clk_gate              = 1'b0;
         contol_signals_select = 1'b0;
         cnt_nxt               = cnt - 4'd1;
         if (cnt == 4'd1) state_nxt = RUN;
      end else if (hz) begin
         clk_gate              = 1'b0;
         contol_signals_select = 1'b0;
         if (LOAD_LAT > 1) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_INIT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // perf_clear wins over the increment; the counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n || perf_clear) begin
         stall_count <= '0;
      end else if (!clk_gate && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Drives two controllers (LOAD_LAT 1 / 16-bit counter and LOAD_LAT 3 / 4-bit counter)
// with shared inputs and checks both against a bubble-budget model of the stall rules.
module tb_hazard_stall_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, rd;
   logic       u1, u2, ex_mr, mem_mr, mem_ready, br, pclr;

   logic        a_cg, a_sel, a_fl, a_fr;
   logic [15:0] a_cnt;
   logic        b_cg, b_sel, b_fl, b_fr;
   logic [3:0]  b_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int rem_a = 0, rem_b = 0, cnt_a = 0, cnt_b = 0;
   logic [3:0] ea, eb;

   always #5 clk = ~clk;

   hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
      .IF_ID_rs1_used(u1), .IF_ID_rs2_used(u2), .ID_EX_rd(rd),
      .ID_EX_memRead(ex_mr), .EX_MEM_memRead(mem_mr), .mem_ready(mem_ready),
      .branch_taken(br), .perf_clear(pclr), .clk_gate(a_cg),
      .contol_signals_select(a_sel), .IF_ID_flush(a_fl), .pipe_freeze(a_fr),
      .stall_count(a_cnt));

   hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
      .IF_ID_rs1_used(u1), .IF_ID_rs2_used(u2), .ID_EX_rd(rd),
      .ID_EX_memRead(ex_mr), .EX_MEM_memRead(mem_mr), .mem_ready(mem_ready),
      .branch_taken(br), .perf_clear(pclr), .clk_gate(b_cg),
      .contol_signals_select(b_sel), .IF_ID_flush(b_fl), .pipe_freeze(b_fr),
      .stall_count(b_cnt));

   // Model: each controller owes "rem" further bubble cycles after the current one.
   function automatic logic hz_f();
      return ex_mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   // Expected {clk_gate, select, flush, freeze} for a controller owing rem bubbles.
   function automatic logic [3:0] exp_out(input int rem);
      if (!rst_n)                return 4'b1100;
      if (mem_mr && !mem_ready)  return 4'b0101;
      if (br)                    return 4'b1010;
      if (rem > 0 || hz_f())     return 4'b0000;
      return 4'b1100;
   endfunction

   function automatic int next_rem(input int lat, input int rem);
      if (!rst_n)               return 0;
      if (mem_mr && !mem_ready) return rem;
      if (br)                   return 0;
      if (rem > 0)              return rem - 1;
      if (hz_f())               return lat - 1;
      return 0;
   endfunction

   function automatic int next_cnt(input int c, input logic cg, input int maxv);
      if (!rst_n || pclr)   return 0;
      if (!cg && c < maxv)  return c + 1;
      return c;
   endfunction

   task automatic model_edge();
      logic [3:0] oa, ob;
      oa = exp_out(rem_a);
      ob = exp_out(rem_b);
      cnt_a = next_cnt(cnt_a, oa[3], 65535);
      cnt_b = next_cnt(cnt_b, ob[3], 15);
      rem_a = next_rem(1, rem_a);
      rem_b = next_rem(3, rem_b);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic applyStimulus_idle();
      rst_n = 1'b1; rs1 = '0; rs2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0;
      ex_mr = 1'b0; mem_mr = 1'b0; mem_ready = 1'b1; br = 1'b0; pclr = 1'b0;
   endtask

   task automatic applyStimulus_hazard();
      ex_mr = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
   endtask

   task automatic test_reset();
      applyStimulus_idle();
      rst_n = 1'b0;
      applyStimulus_hazard();
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp += 1;
         if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== 8'b1100_1100) begin
            n_bad += 1;
            $display("[TB] FAIL reset.outs cyc=%0d got=%b want=11001100", i,
                     {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr});
         end
         n_cmp += 1;
         if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            n_bad += 1;
            $display("[TB] FAIL reset.count cyc=%0d got=%0d/%0d want=0/0", i, a_cnt, b_cnt);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      int bub_a = 0, bub_b = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus_idle();
         if (i == 0) applyStimulus_hazard();
         #1;
         ea = exp_out(rem_a); eb = exp_out(rem_b);
         bub_a += (a_cg == 1'b0) ? 1 : 0;
         bub_b += (b_cg == 1'b0) ? 1 : 0;
         n_cmp += 1;
         if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== {ea, eb}) begin
            n_bad += 1;
            $display("[TB] FAIL load_use.outs cyc=%0d got=%b want=%b", i,
                     {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr}, {ea, eb});
         end
         tick();
      end
      n_cmp += 1;
      if (bub_a != 1 || bub_b != 3 || a_cnt !== 16'd1 || b_cnt !== 4'd3) begin
         n_bad += 1;
         $display("[TB] FAIL load_use.length got bubbles=%0d/%0d counts=%0d/%0d want 1/3 1/3",
                  bub_a, bub_b, a_cnt, b_cnt);
      end
   endtask

   task automatic test_no_hazard();
      for (int i = 0; i < 8; i++) begin
         applyStimulus_idle();
         ex_mr = 1'b1;
         case (i % 4)
            0: begin rd = 5'd0; rs1 = 5'd0; u1 = 1'b1; rs2 = 5'd0; u2 = 1'b1; end
            1: begin rd = 5'd7; rs1 = 5'd7; u1 = 1'b0; rs2 = 5'd3; u2 = 1'b1; end
            2: begin rd = 5'd9; rs2 = 5'd9; u2 = 1'b0; rs1 = 5'd1; u1 = 1'b1; end
            default: begin rd = 5'd4; rs1 = 5'd4; u1 = 1'b1; ex_mr = 1'b0; end
         endcase
         #1;
         n_cmp += 1;
         if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== 8'b1100_1100) begin
            n_bad += 1;
            $display("[TB] FAIL no_hazard.outs cyc=%0d got=%b want=11001100", i,
                     {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr});
         end
         tick();
      end
   endtask

   task automatic test_branch_cancel();
      for (int i = 0; i < 5; i++) begin
         applyStimulus_idle();
         if (i == 0) applyStimulus_hazard();
         if (i == 1) br = 1'b1;
         #1;
         ea = exp_out(rem_a); eb = exp_out(rem_b);
         n_cmp += 1;
         if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== {ea, eb}) begin
            n_bad += 1;
            $display("[TB] FAIL branch.outs cyc=%0d got=%b want=%b", i,
                     {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr}, {ea, eb});
         end
         if (i == 1) begin
            n_cmp += 1;
            if ({b_cg, b_sel, b_fl, b_fr} !== 4'b1010) begin
               n_bad += 1;
               $display("[TB] FAIL branch.flush got=%b want=1010", {b_cg, b_sel, b_fl, b_fr});
            end
         end
         tick();
      end
   endtask

   task automatic test_freeze_in_hold();
      for (int i = 0; i < 8; i++) begin
         applyStimulus_idle();
         if (i == 0) begin applyStimulus_hazard(); pclr = 1'b1; end
         if (i >= 1 && i <= 4) begin mem_mr = 1'b1; mem_ready = 1'b0; end
         #1;
         ea = exp_out(rem_a); eb = exp_out(rem_b);
         n_cmp += 1;
         if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== {ea, eb}) begin
            n_bad += 1;
            $display("[TB] FAIL freeze.outs cyc=%0d got=%b want=%b", i,
                     {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr}, {ea, eb});
         end
         n_cmp += 1;
         if (a_cnt !== 16'(cnt_a) || b_cnt !== 4'(cnt_b)) begin
            n_bad += 1;
            $display("[TB] FAIL freeze.count cyc=%0d got=%0d/%0d want=%0d/%0d",
                     i, a_cnt, b_cnt, cnt_a, cnt_b);
         end
         tick();
      end
      n_cmp += 1;
      if (b_cnt !== 4'd6 || a_cnt !== 16'd4) begin
         n_bad += 1;
         $display("[TB] FAIL freeze.total got=%0d/%0d want=4/6", a_cnt, b_cnt);
      end
   endtask

   task automatic test_saturate_and_reset();
      applyStimulus_idle();
      mem_mr = 1'b1; mem_ready = 1'b0;
      repeat (20) tick();
      #1;
      n_cmp += 1;
      if (b_cnt !== 4'd15 || a_cnt !== 16'(cnt_a)) begin
         n_bad += 1;
         $display("[TB] FAIL saturate.count got=%0d/%0d want=%0d/15", a_cnt, b_cnt, cnt_a);
      end
      applyStimulus_idle();
      applyStimulus_hazard();
      tick();
      rst_n = 1'b0; pclr = 1'b1;
      #1;
      n_cmp += 1;
      if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== 8'b1100_1100) begin
         n_bad += 1;
         $display("[TB] FAIL midhold_reset.outs got=%b want=11001100",
                  {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr});
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus_idle();
         #1;
         n_cmp += 1;
         if ({b_cg, b_sel, b_fl, b_fr} !== 4'b1100 || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
            n_bad += 1;
            $display("[TB] FAIL after_reset cyc=%0d got=%b cnt=%0d/%0d want=1100 cnt=0/0",
                     i, {b_cg, b_sel, b_fl, b_fr}, a_cnt, b_cnt);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n     = ($urandom_range(0, 99) >= 3);
         rd        = 5'($urandom_range(0, 3));
         rs1       = 5'($urandom_range(0, 3));
         rs2       = 5'($urandom_range(0, 3));
         u1        = 1'($urandom_range(0, 1));
         u2        = 1'($urandom_range(0, 1));
         ex_mr     = 1'($urandom_range(0, 1));
         mem_mr    = ($urandom_range(0, 99) < 20);
         mem_ready = ($urandom_range(0, 99) < 40);
         br        = ($urandom_range(0, 99) < 10);
         pclr      = ($urandom_range(0, 99) < 4);
         #1;
         ea = exp_out(rem_a); eb = exp_out(rem_b);
         n_cmp += 1;
         if ({a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr} !== {ea, eb}) begin
            n_bad += 1;
            $display("[TB] FAIL random.outs cyc=%0d got=%b want=%b", i,
                     {a_cg, a_sel, a_fl, a_fr, b_cg, b_sel, b_fl, b_fr}, {ea, eb});
         end
         n_cmp += 1;
         if (a_cnt !== 16'(cnt_a) || b_cnt !== 4'(cnt_b)) begin
            n_bad += 1;
            $display("[TB] FAIL random.count cyc=%0d got=%0d/%0d want=%0d/%0d",
                     i, a_cnt, b_cnt, cnt_a, cnt_b);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch_cancel();
      test_freeze_in_hold();
      test_saturate_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
